// File: rtl/xge_wb_pkg.sv
// Shared types and constants for the xge_mac Wishbone config-bus arbiter.
package xge_wb_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StBus,
    StDone
  } arb_state_e;

  localparam int unsigned WB_ADDR_W       = 8;
  localparam int unsigned WB_DATA_W       = 32;
  localparam logic [31:0] WB_TIMEOUT_DATA = 32'hDEAD_BEEF;

endpackage

// File: rtl/xge_wb_cfg_arbiter_if.sv
// Wishbone master-side bundle between the config arbiter and the xge_mac register port.
interface xge_wb_cfg_arbiter_if #(
  parameter int unsigned ADDR_W = xge_wb_pkg::WB_ADDR_W,
  parameter int unsigned DATA_W = xge_wb_pkg::WB_DATA_W
);

  logic              cyc;
  logic              stb;
  logic              we;
  logic [ADDR_W-1:0] adr;
  logic [DATA_W-1:0] wdat;
  logic [DATA_W-1:0] rdat;
  logic              ack;

  modport master (
    output cyc, stb, we, adr, wdat,
    input  rdat, ack
  );

  modport slave (
    input  cyc, stb, we, adr, wdat,
    output rdat, ack
  );

endinterface

// File: rtl/xge_rr_picker.sv
// Combinational round-robin picker: first set request at or after ptr, wrapping.
module xge_rr_picker #(
  parameter int unsigned NUM_REQ = 2,
  parameter int unsigned IDX_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic [NUM_REQ-1:0] req_i,
  input  logic [IDX_W-1:0]   ptr_i,
  output logic [NUM_REQ-1:0] gnt_o,
  output logic [IDX_W-1:0]   idx_o,
  output logic               any_o
);

  logic [IDX_W-1:0] j;

  always_comb begin
    any_o = 1'b0;
    idx_o = '0;
    gnt_o = '0;
    j     = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      j = IDX_W'((32'(ptr_i) + i) % NUM_REQ);
      if (!any_o && req_i[j]) begin
        any_o = 1'b1;
        idx_o = j;
      end
    end
    gnt_o[idx_o] = any_o;
  end

endmodule

// File: rtl/xge_wb_cfg_arbiter.sv
// Round-robin arbiter sharing the xge_mac Wishbone register port among NUM_REQ requesters.
// Optional ack watchdog enabled by defining WB_ARB_TIMEOUT_EN.
module xge_wb_cfg_arbiter
  import xge_wb_pkg::*;
#(
  parameter int unsigned NUM_REQ     = 2,
  parameter int unsigned ADDR_W      = WB_ADDR_W,
  parameter int unsigned DATA_W      = WB_DATA_W,
  parameter int unsigned TIMEOUT_CYC = 255
) (
  input  logic                      wb_clk_i,
  input  logic                      wb_rst_i,
  input  logic [NUM_REQ-1:0]        req_i,
  input  logic [NUM_REQ-1:0]        req_we_i,
  input  logic [NUM_REQ*ADDR_W-1:0] req_adr_i,
  input  logic [NUM_REQ*DATA_W-1:0] req_dat_i,
  output logic [NUM_REQ-1:0]        done_o,
  output logic [NUM_REQ-1:0]        err_o,
  output logic [DATA_W-1:0]         rdat_o,
  xge_wb_cfg_arbiter_if.master      wb
);

  localparam int unsigned IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  if (NUM_REQ < 2 || NUM_REQ > 8 || TIMEOUT_CYC < 1) begin : g_bad_params
    $error("xge_wb_cfg_arbiter: unsupported parameter value");
  end

  arb_state_e state_q, state_d;
  logic [IDX_W-1:0]   ptr_q, ptr_d;
  logic [IDX_W-1:0]   gidx_q, gidx_d;
  logic               cyc_q, cyc_d;
  logic               we_q, we_d;
  logic [ADDR_W-1:0]  adr_q, adr_d;
  logic [DATA_W-1:0]  wdat_q, wdat_d;
  logic [DATA_W-1:0]  rdat_q, rdat_d;
  logic [NUM_REQ-1:0] done_q, done_d;

  logic [NUM_REQ-1:0] pick_gnt;
  logic [IDX_W-1:0]   pick_idx;
  logic               pick_any;
  logic [IDX_W-1:0]   ptr_nxt;
  logic               sel_we;
  logic [ADDR_W-1:0]  sel_adr;
  logic [DATA_W-1:0]  sel_wdat;

  xge_rr_picker #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (IDX_W)
  ) u_picker (
    .req_i (req_i),
    .ptr_i (ptr_q),
    .gnt_o (pick_gnt),
    .idx_o (pick_idx),
    .any_o (pick_any)
  );

  // One-hot AND-OR select of the winning requester's command.
  always_comb begin
    sel_we   = 1'b0;
    sel_adr  = '0;
    sel_wdat = '0;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      if (pick_gnt[k]) begin
        sel_we   = req_we_i[k];
        sel_adr  = req_adr_i[k*ADDR_W +: ADDR_W];
        sel_wdat = req_dat_i[k*DATA_W +: DATA_W];
      end
    end
  end

  assign ptr_nxt = (pick_idx == IDX_W'(NUM_REQ - 1)) ? '0 : pick_idx + IDX_W'(1);

`ifdef WB_ARB_TIMEOUT_EN
  localparam int unsigned CNT_W = $clog2(TIMEOUT_CYC + 1);
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [NUM_REQ-1:0] err_q, err_d;
`endif

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    gidx_d  = gidx_q;
    cyc_d   = cyc_q;
    we_d    = we_q;
    adr_d   = adr_q;
    wdat_d  = wdat_q;
    rdat_d  = rdat_q;
    done_d  = '0;
`ifdef WB_ARB_TIMEOUT_EN
    err_d   = '0;
    cnt_d   = cnt_q;
`endif
    unique case (state_q)
      StIdle: begin
        if (pick_any) begin
          gidx_d  = pick_idx;
          we_d    = sel_we;
          adr_d   = sel_adr;
          wdat_d  = sel_wdat;
          cyc_d   = 1'b1;
          ptr_d   = ptr_nxt;
          state_d = StBus;
`ifdef WB_ARB_TIMEOUT_EN
          cnt_d   = '0;
`endif
        end
      end
      StBus: begin
        if (wb.ack) begin
          cyc_d          = 1'b0;
          done_d[gidx_q] = 1'b1;
          if (!we_q) rdat_d = wb.rdat;
          state_d        = StDone;
        end
`ifdef WB_ARB_TIMEOUT_EN
        // cnt_q counts BUS cycles already spent; the TIMEOUT_CYC-th one without ack gives up.
        else if (cnt_q == CNT_W'(TIMEOUT_CYC - 1)) begin
          cyc_d          = 1'b0;
          done_d[gidx_q] = 1'b1;
          err_d[gidx_q]  = 1'b1;
          rdat_d         = DATA_W'(WB_TIMEOUT_DATA);
          state_d        = StDone;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
`endif
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      state_q <= StIdle;
      ptr_q   <= '0;
      gidx_q  <= '0;
      cyc_q   <= 1'b0;
      we_q    <= 1'b0;
      adr_q   <= '0;
      wdat_q  <= '0;
      rdat_q  <= '0;
      done_q  <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      gidx_q  <= gidx_d;
      cyc_q   <= cyc_d;
      we_q    <= we_d;
      adr_q   <= adr_d;
      wdat_q  <= wdat_d;
      rdat_q  <= rdat_d;
      done_q  <= done_d;
    end
  end

`ifdef WB_ARB_TIMEOUT_EN
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      cnt_q <= '0;
      err_q <= '0;
    end else begin
      cnt_q <= cnt_d;
      err_q <= err_d;
    end
  end

  assign err_o = err_q;
`else
  assign err_o = '0;
`endif

  assign done_o  = done_q;
  assign rdat_o  = rdat_q;
  assign wb.cyc  = cyc_q;
  assign wb.stb  = cyc_q;
  assign wb.we   = we_q;
  assign wb.adr  = adr_q;
  assign wb.wdat = wdat_q;

endmodule

// File: tb/tb_xge_wb_cfg_arbiter.sv
// Directed bench for xge_wb_cfg_arbiter with a queue scoreboard and a negedge bus/done monitor.
module tb_xge_wb_cfg_arbiter;

  typedef struct packed {
    logic        we;
    logic [7:0]  adr;
    logic [31:0] dat;
  } bus_t;

  typedef struct packed {
    logic [1:0]  done;
    logic [1:0]  err;
    logic [31:0] rdat;
  } done_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [1:0]  req = '0;
  logic [1:0]  req_we = '0;
  logic [15:0] req_adr = '0;
  logic [63:0] req_dat = '0;
  logic [1:0]  done;
  logic [1:0]  err;
  logic [31:0] rdat;

  logic        slv_ack = 1'b0;
  logic        stray_ack = 1'b0;
  logic [31:0] slv_rdat = '0;
  int          ack_dly = 0;
  bit          ack_en = 1'b1;
  int          dly_cnt = 0;

  int total = 0;
  int bad = 0;

  bus_t  exp_bus[$];
  done_t exp_done[$];

  xge_wb_cfg_arbiter_if #(.ADDR_W(8), .DATA_W(32)) wb_bus ();

  assign wb_bus.ack  = slv_ack | stray_ack;
  assign wb_bus.rdat = slv_rdat;

  xge_wb_cfg_arbiter #(
    .NUM_REQ     (2),
    .ADDR_W      (8),
    .DATA_W      (32),
    .TIMEOUT_CYC (16)
  ) dut (
    .wb_clk_i  (clk),
    .wb_rst_i  (rst),
    .req_i     (req),
    .req_we_i  (req_we),
    .req_adr_i (req_adr),
    .req_dat_i (req_dat),
    .done_o    (done),
    .err_o     (err),
    .rdat_o    (rdat),
    .wb        (wb_bus)
  );

  always #5 clk = ~clk;

  // Slave model: ack after ack_dly+1 sampled stb cycles, one-cycle pulse.
  always @(posedge clk) begin
    if (wb_bus.stb && !slv_ack && ack_en) begin
      if (dly_cnt >= ack_dly) begin
        slv_ack <= 1'b1;
        dly_cnt <= 0;
      end else begin
        dly_cnt <= dly_cnt + 1;
      end
    end else begin
      slv_ack <= 1'b0;
      if (!wb_bus.stb) dly_cnt <= 0;
    end
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic note_fail(input string name);
    total++;
    bad++;
    $display("FAIL %s: event missing or unexpected", name);
  endtask

  // Monitor: pops scoreboard entries when a bus cycle starts or a done pulse appears.
  logic cyc_prev = 1'b0;
  bus_t cur;
  always @(negedge clk) begin
    if (wb_bus.cyc && !cyc_prev) begin
      if (exp_bus.size() == 0) begin
        note_fail("unexpected_bus_cycle");
      end else begin
        cur = exp_bus.pop_front();
        check("bus_we", 64'(wb_bus.we), 64'(cur.we));
        check("bus_adr", 64'(wb_bus.adr), 64'(cur.adr));
        if (cur.we) check("bus_wdat", 64'(wb_bus.wdat), 64'(cur.dat));
      end
    end else if (wb_bus.cyc) begin
      check("bus_adr_stable", 64'(wb_bus.adr), 64'(cur.adr));
    end
    if (wb_bus.cyc) check("stb_follows_cyc", 64'(wb_bus.stb), 64'd1);
    if (done != 2'b00) begin
      check("done_onehot", 64'($countones(done)), 64'd1);
      check("cyc_low_at_done", 64'(wb_bus.cyc), 64'd0);
      if (exp_done.size() == 0) begin
        note_fail("unexpected_done");
      end else begin
        done_t e;
        e = exp_done.pop_front();
        check("done_vec", 64'(done), 64'(e.done));
        check("err_vec", 64'(err), 64'(e.err));
        check("rdat", 64'(rdat), 64'(e.rdat));
      end
    end else if (err != 2'b00) begin
      note_fail("err_without_done");
    end
    cyc_prev = wb_bus.cyc;
  end

  task automatic push_exp(input int k, input logic we, input logic [7:0] adr,
                          input logic [31:0] dat, input logic [31:0] exp_rdat,
                          input logic exp_err);
    logic [1:0] onehot;
    onehot = 2'(1 << k);
    req_we[k]          = we;
    req_adr[k*8 +: 8]  = adr;
    req_dat[k*32 +: 32] = dat;
    exp_bus.push_back('{we, adr, dat});
    exp_done.push_back('{onehot, exp_err ? onehot : 2'b00, exp_rdat});
  endtask

  task automatic wait_done(input int k, input string name, output int lat);
    bit seen;
    seen = 1'b0;
    lat = 0;
    while (!seen && lat < 200) begin
      @(negedge clk);
      lat++;
      if (done[k]) seen = 1'b1;
    end
    if (!seen) note_fail(name);
  endtask

  task automatic access(input int k, input logic we, input logic [7:0] adr,
                        input logic [31:0] dat, input logic [31:0] exp_rdat,
                        input logic exp_err, output int lat);
    bit seen;
    push_exp(k, we, adr, dat, exp_rdat, exp_err);
    req[k] = 1'b1;
    seen = 1'b0;
    lat = 0;
    while (!seen && lat < 200) begin
      @(negedge clk);
      lat++;
      if (lat == 1) check("req_to_stb", 64'({wb_bus.cyc, wb_bus.stb}), 64'd3);
      if (done[k]) seen = 1'b1;
    end
    if (!seen) note_fail("access_done_timeout");
    req[k] = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat;
    int k;
    bit seen;

    repeat (3) @(negedge clk);
    check("rst_cyc", 64'(wb_bus.cyc), 64'd0);
    check("rst_stb", 64'(wb_bus.stb), 64'd0);
    check("rst_we", 64'(wb_bus.we), 64'd0);
    check("rst_adr", 64'(wb_bus.adr), 64'd0);
    check("rst_wdat", 64'(wb_bus.wdat), 64'd0);
    check("rst_done", 64'(done), 64'd0);
    check("rst_err", 64'(err), 64'd0);
    check("rst_rdat", 64'(rdat), 64'd0);
    rst = 1'b0;
    @(negedge clk);

    // Write from requester 0, ack three cycles after stb.
    ack_dly = 2;
    access(0, 1'b1, 8'h00, 32'h1, 32'h0, 1'b0, lat);
    check("t1_latency", 64'(lat), 64'd5);

    // Read from requester 1 with immediate ack.
    ack_dly = 0;
    slv_rdat = 32'h0000_00A5;
    access(1, 1'b0, 8'h08, 32'h0, 32'h0000_00A5, 1'b0, lat);
    check("t2_latency", 64'(lat), 64'd3);
    slv_rdat = 32'h5555_5555;
    @(negedge clk);
    check("rdat_held", 64'(rdat), 64'h0000_00A5);

    // Stray ack while idle must not start or finish anything.
    stray_ack = 1'b1;
    @(negedge clk);
    stray_ack = 1'b0;
    check("stray_ack_cyc", 64'(wb_bus.cyc), 64'd0);
    @(negedge clk);
    check("stray_ack_done", 64'(done), 64'd0);

`ifdef WB_ARB_TIMEOUT_EN
    ack_en = 1'b0;
    access(0, 1'b0, 8'h40, 32'h0, 32'hDEAD_BEEF, 1'b1, lat);
    check("t4_timeout_latency", 64'(lat), 64'd17);
    ack_en = 1'b1;
    slv_rdat = 32'h0000_1234;
    access(0, 1'b0, 8'h44, 32'h0, 32'h0000_1234, 1'b0, lat);
    check("t4_after_timeout_latency", 64'(lat), 64'd3);
`endif

    // Both requesters contend from reset: grants alternate 0,1,0,1.
    rst = 1'b1;
    ack_dly = 1;
    push_exp(0, 1'b1, 8'h10, 32'h1111_0000, 32'h0, 1'b0);
    push_exp(1, 1'b1, 8'h20, 32'h2222_0000, 32'h0, 1'b0);
    exp_bus.push_back('{1'b1, 8'h10, 32'h1111_0000});
    exp_done.push_back('{2'b01, 2'b00, 32'h0});
    exp_bus.push_back('{1'b1, 8'h20, 32'h2222_0000});
    exp_done.push_back('{2'b10, 2'b00, 32'h0});
    req = 2'b11;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    for (int g = 0; g < 4; g++) begin
      seen = 1'b0;
      lat = 0;
      while (!seen && lat < 200) begin
        @(negedge clk);
        lat++;
        if (done != 2'b00) seen = 1'b1;
      end
      if (!seen) note_fail("t3_done_timeout");
      k = done[1] ? 1 : 0;
      if (g == 3) begin
        req = 2'b00;
      end else begin
        req[k] = 1'b0;
        @(negedge clk);
        req[k] = 1'b1;
      end
    end
    repeat (2) @(negedge clk);

    // Reset two cycles into BUS aborts silently and clears the rr pointer.
    ack_en = 1'b0;
    ack_dly = 0;
    req_we[0] = 1'b0;
    req_adr[7:0] = 8'h30;
    exp_bus.push_back('{1'b0, 8'h30, req_dat[31:0]});
    req[0] = 1'b1;
    @(negedge clk);
    check("t5_stb_up", 64'(wb_bus.stb), 64'd1);
    @(negedge clk);
    rst = 1'b1;
    req = 2'b00;
    @(negedge clk);
    check("t5_cyc_dropped", 64'(wb_bus.cyc), 64'd0);
    check("t5_stb_dropped", 64'(wb_bus.stb), 64'd0);
    check("t5_no_done", 64'(done), 64'd0);
    rst = 1'b0;
    ack_en = 1'b1;
    @(negedge clk);
    push_exp(0, 1'b1, 8'h50, 32'h5050_5050, 32'h0, 1'b0);
    push_exp(1, 1'b1, 8'h60, 32'h6060_6060, 32'h0, 1'b0);
    req = 2'b11;
    wait_done(0, "t5_done0_timeout", lat);
    req[0] = 1'b0;
    wait_done(1, "t5_done1_timeout", lat);
    req[1] = 1'b0;

    repeat (5) @(negedge clk);
    check("bus_queue_drained", 64'(exp_bus.size()), 64'd0);
    check("done_queue_drained", 64'(exp_done.size()), 64'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
